// File: rtl/scaler_matrix_sched.sv
// rtl/scaler_matrix_sched.sv - vertical line-RAM ring scheduler for the scaler
// Tracks resident lines, steps the SRC_H/DST_H accumulator per output row and returns lines to the writer.
module scaler_matrix_sched #(
  parameter int KERNEL_MAX       = 4,
  parameter int RAM_NUM          = KERNEL_MAX + 1,
  parameter int RAM_NUM_BITWIDTH = $clog2(RAM_NUM),
  parameter int H_BITWIDTH       = 12,
  parameter int KERNEL_BITWIDTH  = $clog2(KERNEL_MAX)
) (
  input  logic                        s_clk,
  input  logic                        s_rst_n,
  input  logic                        s_start,
  input  logic [H_BITWIDTH-1:0]       cfg_src_h,
  input  logic [H_BITWIDTH-1:0]       cfg_dst_h,
  input  logic [KERNEL_BITWIDTH:0]    cfg_kernel,
  input  logic                        ram_write_done,
  output logic                        rd_start,
  output logic [RAM_NUM_BITWIDTH-1:0] rd_base_sel,
  output logic [H_BITWIDTH-1:0]       rd_phase,
  output logic [KERNEL_BITWIDTH:0]    rd_taps,
  input  logic                        rd_done,
  output logic                        ram_read_done,
  output logic [RAM_NUM_BITWIDTH-1:0] ram_read_num,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int H  = H_BITWIDTH;
  localparam int RB = RAM_NUM_BITWIDTH;
  localparam int KW = KERNEL_BITWIDTH + 1;
  localparam logic [H-1:0]  ONE_H    = H'(1);
  localparam logic [H-1:0]  REL_MAX  = H'(RAM_NUM - 1);
  localparam logic [RB-1:0] SEL_LAST = RB'(RAM_NUM - 1);
  localparam logic [KW-1:0] K_MAX    = KW'(KERNEL_MAX);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_RD, ADV, STEP, FLUSH} state_t;

  state_t        state;
  logic [H-1:0]  src_h, dst_h, wr_cnt, rel_cnt, top, row;
  logic [H:0]    acc;
  logic [KW-1:0] k_lat;
  logic [RB-1:0] top_sel;
  logic          wr_prev;
  logic [1:0]    rel_cool;

  logic [KW-1:0] k_eff;
  logic [H:0]    top_k;
  logic [H-1:0]  src_m1, need, target, lim, avail;
  logic [KW-1:0] taps;
  logic [RB-1:0] rel_n;
  logic          wr_rise;

  always_comb begin
    k_eff = cfg_kernel;
    if (cfg_kernel == '0)
      k_eff = KW'(1);
    else if (cfg_kernel > K_MAX)
      k_eff = K_MAX;
  end

  // Bottom line needed by the current row, clamped to the last source line.
  always_comb begin
    src_m1 = src_h - ONE_H;
    top_k  = {1'b0, top} + (H+1)'(k_lat) - (H+1)'(1);
    need   = (top_k > {1'b0, src_m1}) ? src_m1 : H'(top_k);
    taps   = KW'(need - top) + KW'(1);
  end

  // Lines above top are finished; during FLUSH everything written can go back.
  always_comb begin
    target  = (state == FLUSH) ? src_h : top;
    lim     = (target < wr_cnt) ? target : wr_cnt;
    avail   = lim - rel_cnt;
    rel_n   = (avail > REL_MAX) ? SEL_LAST : RB'(avail);
    wr_rise = ram_write_done & ~wr_prev;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state         <= IDLE;
      src_h         <= '0;
      dst_h         <= '0;
      k_lat         <= '0;
      wr_cnt        <= '0;
      rel_cnt       <= '0;
      top           <= '0;
      top_sel       <= '0;
      acc           <= '0;
      row           <= '0;
      wr_prev       <= 1'b0;
      rel_cool      <= '0;
      rd_start      <= 1'b0;
      rd_base_sel   <= '0;
      rd_phase      <= '0;
      rd_taps       <= '0;
      ram_read_done <= 1'b0;
      ram_read_num  <= '0;
      frame_done    <= 1'b0;
    end else begin
      rd_start      <= 1'b0;
      ram_read_done <= 1'b0;
      frame_done    <= 1'b0;
      wr_prev       <= ram_write_done;

      if (state != IDLE) begin
        if (wr_rise && (wr_cnt < src_h))
          wr_cnt <= wr_cnt + ONE_H;
        // Two idle cycles after each release so the writer sees a clean edge.
        if (rel_cool != 2'd0) begin
          rel_cool <= rel_cool - 2'd1;
        end else if (avail != '0) begin
          ram_read_done <= 1'b1;
          ram_read_num  <= rel_n;
          rel_cnt       <= rel_cnt + H'(rel_n);
          rel_cool      <= 2'd2;
        end
      end

      case (state)
        IDLE: begin
          if (s_start) begin
            src_h    <= cfg_src_h;
            dst_h    <= cfg_dst_h;
            k_lat    <= k_eff;
            wr_cnt   <= '0;
            rel_cnt  <= '0;
            top      <= '0;
            top_sel  <= '0;
            acc      <= '0;
            row      <= '0;
            rel_cool <= '0;
            state    <= ((cfg_src_h == '0) || (cfg_dst_h == '0)) ? FLUSH : CHECK;
          end
        end
        CHECK: begin
          if (wr_cnt > need) begin
            rd_start    <= 1'b1;
            rd_base_sel <= top_sel;
            rd_phase    <= acc[H-1:0];
            rd_taps     <= taps;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_RD;
        WAIT_RD: begin
          if (rd_done)
            state <= ADV;
        end
        ADV: begin
          acc   <= acc + {1'b0, src_h};
          row   <= row + ONE_H;
          state <= STEP;
        end
        STEP: begin
          if (acc >= {1'b0, dst_h}) begin
            acc <= acc - {1'b0, dst_h};
            if (top < src_m1) begin
              top     <= top + ONE_H;
              top_sel <= (top_sel == SEL_LAST) ? '0 : top_sel + RB'(1);
            end
          end else begin
            state <= (row == dst_h) ? FLUSH : CHECK;
          end
        end
        FLUSH: begin
          if (rel_cnt == src_h) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scaler_matrix_sched.sv
// tb/tb_scaler_matrix_sched.sv - directed bench for scaler_matrix_sched
// A gated writer model and a reader model drive frames; row outputs are checked against hand tables.
module tb_scaler_matrix_sched;

  logic        s_clk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        s_start = 1'b0;
  logic [11:0] cfg_src_h = '0;
  logic [11:0] cfg_dst_h = '0;
  logic [2:0]  cfg_kernel = '0;
  logic        ram_write_done = 1'b0;
  logic        rd_done = 1'b0;
  logic        rd_start;
  logic [2:0]  rd_base_sel;
  logic [11:0] rd_phase;
  logic [2:0]  rd_taps;
  logic        ram_read_done;
  logic [2:0]  ram_read_num;
  logic        frame_done;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int writes = 0;
  int released = 0;
  int src_lim = 0;
  bit wr_en = 1'b0;
  int rd_cnt = 0;
  int cyc = 0;
  int last_rel = -100;
  int exp_base[$];
  int exp_phase[$];
  int exp_taps[$];

  always #5 s_clk = ~s_clk;

  scaler_matrix_sched dut (
    .s_clk          (s_clk),
    .s_rst_n        (s_rst_n),
    .s_start        (s_start),
    .cfg_src_h      (cfg_src_h),
    .cfg_dst_h      (cfg_dst_h),
    .cfg_kernel     (cfg_kernel),
    .ram_write_done (ram_write_done),
    .rd_start       (rd_start),
    .rd_base_sel    (rd_base_sel),
    .rd_phase       (rd_phase),
    .rd_taps        (rd_taps),
    .rd_done        (rd_done),
    .ram_read_done  (ram_read_done),
    .ram_read_num   (ram_read_num),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int b, input int p, input int tp);
    exp_base.push_back(b);
    exp_phase.push_back(p);
    exp_taps.push_back(tp);
  endtask

  task automatic pulse_start();
    @(posedge s_clk); #1 s_start = 1'b1;
    @(posedge s_clk); #1 s_start = 1'b0;
  endtask

  // Writer: one stretched edge per line, never more than five lines outstanding.
  initial forever begin
    @(posedge s_clk);
    if (wr_en && (writes < src_lim) && (writes - released < 5)) begin
      #1 ram_write_done = 1'b1;
      writes++;
      repeat (2) @(posedge s_clk);
      #1 ram_write_done = 1'b0;
      repeat (2) @(posedge s_clk);
    end
  end

  always @(negedge s_clk) begin
    cyc++;
    if (rd_start) rd_cnt++;
    if (ram_read_done) begin
      check("rel_gap", int'(cyc - last_rel >= 3), 1);
      check("rel_num_range", int'(ram_read_num >= 3'd1 && ram_read_num <= 3'd4), 1);
      last_rel = cyc;
      released += int'(ram_read_num);
      check("rel_le_wr", int'(released <= writes), 1);
    end
  end

  task automatic run_frame(input string name, input int src, input int dst, input int k,
                           input int poke_row, input int abort_row);
    int t;
    int nrows;
    nrows = exp_base.size();
    writes = 0; released = 0; rd_cnt = 0; src_lim = src; last_rel = -100;
    cfg_src_h = 12'(src); cfg_dst_h = 12'(dst); cfg_kernel = 3'(k);
    pulse_start();
    wr_en = 1'b1;
    for (int i = 0; i < nrows; i++) begin
      t = 0;
      do begin @(negedge s_clk); t++; end while (!rd_start && t < 1000);
      check($sformatf("%s_rd_start%0d", name, i), int'(rd_start), 1);
      check($sformatf("%s_base%0d", name, i), int'(rd_base_sel), exp_base[i]);
      check($sformatf("%s_phase%0d", name, i), int'(rd_phase), exp_phase[i]);
      check($sformatf("%s_taps%0d", name, i), int'(rd_taps), exp_taps[i]);
      if (i == abort_row) begin
        @(posedge s_clk); #3;
        check({name, "_busy_before"}, int'(busy), 1);
        s_rst_n = 1'b0;
        #1;
        check({name, "_busy_rst"}, int'(busy), 0);
        check({name, "_base_rst"}, int'(rd_base_sel), 0);
        check({name, "_taps_rst"}, int'(rd_taps), 0);
        check({name, "_pulses_rst"}, int'({rd_start, ram_read_done, frame_done}), 0);
        check({name, "_phase_num_rst"}, int'({rd_phase, ram_read_num}), 0);
        wr_en = 1'b0;
        repeat (10) @(posedge s_clk);
        #1 s_rst_n = 1'b1;
        exp_base.delete(); exp_phase.delete(); exp_taps.delete();
        return;
      end
      if (i == poke_row) begin
        cfg_src_h = 12'd1; cfg_dst_h = 12'd2; cfg_kernel = 3'd1;
        pulse_start();
        cfg_src_h = 12'(src); cfg_dst_h = 12'(dst); cfg_kernel = 3'(k);
      end
      repeat (2) @(posedge s_clk);
      #1 rd_done = 1'b1;
      @(posedge s_clk); #1 rd_done = 1'b0;
    end
    t = 0;
    do begin @(negedge s_clk); t++; end while (!frame_done && t < 2000);
    check({name, "_frame_done"}, int'(frame_done), 1);
    check({name, "_released"}, released, src);
    check({name, "_rows"}, rd_cnt, nrows);
    wr_en = 1'b0;
    exp_base.delete(); exp_phase.delete(); exp_taps.delete();
    repeat (3) @(posedge s_clk);
  endtask

  task automatic run_empty(input string name, input int src, input int dst);
    int t;
    rd_cnt = 0; src_lim = 0; writes = 0; released = 0;
    cfg_src_h = 12'(src); cfg_dst_h = 12'(dst); cfg_kernel = 3'd2;
    pulse_start();
    t = 0;
    do begin @(negedge s_clk); t++; end while (!frame_done && t < 2);
    check({name, "_frame_done_2cyc"}, int'(frame_done), 1);
    repeat (3) @(posedge s_clk);
    check({name, "_no_rd_start"}, rd_cnt, 0);
    check({name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge s_clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({rd_start, ram_read_done, frame_done}), 0);
    check("rst_rd_fields", int'({rd_base_sel, rd_phase, rd_taps, ram_read_num}), 0);
    s_rst_n = 1'b1;

    push_exp(0, 0, 2); push_exp(1, 0, 2); push_exp(2, 0, 2); push_exp(3, 0, 1);
    run_frame("unity", 4, 4, 2, -1, -1);

    for (int i = 0; i < 8; i++) push_exp(i / 2, (i % 2) * 4, (i >= 6) ? 1 : 2);
    run_frame("up2x", 4, 8, 2, -1, -1);

    push_exp(0, 0, 4); push_exp(4, 0, 4); push_exp(3, 0, 4); push_exp(2, 0, 4);
    run_frame("down4x", 16, 4, 4, -1, -1);

    for (int i = 0; i < 20; i++) push_exp(i % 5, 0, (i <= 16) ? 4 : 20 - i);
    run_frame("wrap", 20, 20, 4, -1, -1);

    push_exp(0, 0, 1); push_exp(1, 0, 1); push_exp(2, 0, 1);
    run_frame("k0", 3, 3, 0, -1, -1);

    for (int i = 0; i < 6; i++) push_exp(i % 5, 0, (6 - i > 4) ? 4 : 6 - i);
    run_frame("k7_poke", 6, 6, 7, 2, -1);

    run_empty("dst0", 0, 0);
    run_empty("src0", 0, 5);

    push_exp(0, 0, 2); push_exp(1, 0, 2);
    run_frame("abort", 8, 8, 2, -1, 1);

    push_exp(0, 0, 2); push_exp(1, 0, 2); push_exp(2, 0, 2); push_exp(3, 0, 1);
    run_frame("post_rst", 4, 4, 2, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scaler_matrix_sched.md
Name: scaler_matrix_sched

Overview:
- Vertical scheduler for the scaler's line-RAM ring, which holds RAM_NUM = KERNEL_MAX+1 line RAMs filled by the matrix writer.
- Counts lines written into the ring and computes the source top line and phase for each output row with a SRC_H/DST_H accumulator.
- Starts the matrix reader once every required line is resident.
- Returns consumed lines to the writer through ram_read_done and ram_read_num.

Parameters:
- KERNEL_MAX, 4, maximum vertical taps.
- RAM_NUM, KERNEL_MAX+1, number of line RAMs in the ring.
- RAM_NUM_BITWIDTH, CLOG2(RAM_NUM), width of ring index and release count.
- H_BITWIDTH, 12, width of line and row counters and of the accumulator.

Ports:
- s_clk, in, 1: clock.
- s_rst_n, in, 1: asynchronous active-low reset.
- s_start, in, 1: frame start pulse.
- cfg_src_h, in, H_BITWIDTH: source line count.
- cfg_dst_h, in, H_BITWIDTH: output row count.
- cfg_kernel, in, KERNEL_BITWIDTH+1: vertical taps.
- ram_write_done, in, 1: writer line-complete flag. It is a stretched level; count its rising edges.
- rd_start, out, 1: one-cycle pulse starting an output row.
- rd_base_sel, out, RAM_NUM_BITWIDTH: ring index of the top line for that row.
- rd_phase, out, H_BITWIDTH: accumulator remainder (0..cfg_dst_h-1) for that row.
- rd_taps, out, KERNEL_BITWIDTH+1: valid taps for the row after bottom clamp.
- rd_done, in, 1: reader finished the row.
- ram_read_done, out, 1: one-cycle line-release pulse to the writer.
- ram_read_num, out, RAM_NUM_BITWIDTH: number of lines released with that pulse.
- frame_done, out, 1: one-cycle end-of-frame pulse.
- busy, out, 1: high in every state except IDLE.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, all counters 0, state IDLE.
- Reset asserted mid-frame aborts immediately. No release pulse is emitted.
- Taps: K = cfg_kernel, with 0 forced to 1 and values above KERNEL_MAX forced to KERNEL_MAX.
- s_start in IDLE latches cfg_src_h, cfg_dst_h and K. s_start outside IDLE is ignored.
- Counters:
  - wr_cnt: +1 per ram_write_done rising edge, saturating at src_h.
  - rel_cnt: lines released so far.
  - top: current source top line.
  - acc: accumulator remainder.
  - row: output rows issued.
  - top_sel: ring index of top, wrapping RAM_NUM-1 -> 0.
- State machine:
  - IDLE -> CHECK on s_start. Go to FLUSH instead if src_h==0 or dst_h==0.
  - CHECK: need = min(top+K-1, src_h-1). Go to ISSUE when wr_cnt > need; otherwise stay.
  - ISSUE: one cycle. Pulse rd_start with rd_base_sel=top_sel, rd_phase=acc, rd_taps=need-top+1. These values are held until the next ISSUE. Then go to WAIT_RD.
  - WAIT_RD -> ADV on rd_done. An rd_done pulse in any other state is ignored.
  - ADV: acc += src_h, then row++. Go to STEP.
  - STEP: while acc >= dst_h, do acc -= dst_h, top++, top_sel++, one subtraction per cycle.
    - If top reaches src_h-1, hold top and top_sel and discard further steps.
    - When done: go to FLUSH if row==dst_h, else to CHECK.
  - FLUSH: wait until rel_cnt==src_h, then pulse frame_done and go to IDLE.
- Release engine (runs in parallel):
  - target = top during the frame, src_h in FLUSH.
  - avail = min(target, wr_cnt) - rel_cnt.
  - When avail>0 and the engine is idle: pulse ram_read_done with ram_read_num=min(avail, RAM_NUM-1), and add that value to rel_cnt in the same cycle.
  - After each pulse, ram_read_done stays low for at least 2 cycles, because the writer edge-detects it.
  - Lines skipped by downscaling are released only after they are written. The ring therefore never overflows, and the writer is never starved.
- Simultaneous events: a ram_write_done edge and a release in the same cycle update wr_cnt and rel_cnt independently.
- Invariant: wr_cnt - rel_cnt <= RAM_NUM at all times. This is guaranteed because K <= KERNEL_MAX.

Test Plan:
1. Reset with src_h=4, dst_h=4, K=2. Assert s_start. Send 2 write edges -> rd_start base 0, phase 0, taps 2. Each rd_done advances top by 1 and releases 1 line. Rows 3 and 4 have taps 2 and 1 (clamped at src_h-1=3). Release total = 4, then frame_done.
2. 2x upscale: src_h=4, dst_h=8, K=2 -> top sequence 0,0,1,1,2,2,3,3 and phase sequence 0,4,0,4,... Exactly 8 rd_start pulses.
3. 4x downscale: src_h=16, dst_h=4, K=4 -> tops 0,4,8,12. Release pulses carry ram_read_num <= 4, and the last release happens only after the 16th write edge.
4. Ring wrap: src_h=20, dst_h=20, K=4 -> rd_base_sel follows 0,1,2,3,4,0,1,... wr_cnt - rel_cnt never exceeds 5.
5. Edge cases:
   - dst_h=0 -> frame_done within 2 cycles of s_start, and no rd_start.
   - K=0 -> taps=1.
   - K=7 -> taps clamp to 4.
   - s_start asserted while busy -> no effect.
6. Assert s_rst_n low mid-WAIT_RD -> all outputs 0 asynchronously. A new frame after reset runs correctly from top 0.
